// File: rtl/cnl_result_collector.sv
// cnl_result_collector: merges per-quad result streams into one ordered stream tagged with row/col/depth.
module cnl_result_collector #(
    parameter int C_NUM_CH      = 4,
    parameter int C_DATA_WIDTH  = 16,
    parameter int C_ROW_WIDTH   = 10,
    parameter int C_COL_WIDTH   = 10,
    parameter int C_DEPTH_WIDTH = 10
) (
    input  logic                             clk_if,
    input  logic                             rst,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [C_ROW_WIDTH-1:0]           cfg_num_output_rows,
    input  logic [C_COL_WIDTH-1:0]           cfg_num_output_cols,
    input  logic [C_DEPTH_WIDTH-1:0]         cfg_num_kernels,
    input  logic [C_NUM_CH-1:0]              result_valid,
    output logic [C_NUM_CH-1:0]              result_accept,
    input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] result_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [C_DATA_WIDTH-1:0]          out_data,
    output logic [C_ROW_WIDTH-1:0]           out_row,
    output logic [C_COL_WIDTH-1:0]           out_col,
    output logic [C_DEPTH_WIDTH-1:0]         out_depth,
    output logic                             out_last,
    output logic                             job_complete,
    input  logic                             job_complete_ack
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                   state_q, state_d;
    logic [C_ROW_WIDTH-1:0]   rows_q, rows_d, row_q, row_d, out_row_q, out_row_d;
    logic [C_COL_WIDTH-1:0]   cols_q, cols_d, col_q, col_d, out_col_q, out_col_d;
    logic [C_DEPTH_WIDTH-1:0] kern_q, kern_d, depth_q, depth_d, out_depth_q, out_depth_d;
    logic [C_DATA_WIDTH-1:0]  out_data_q, out_data_d, sel_data;
    logic [C_DEPTH_WIDTH-1:0] sel;
    logic                     out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                     job_complete_q, job_complete_d;
    logic                     can_load, xfer, last_hit, depth_wrap, col_wrap;

    always_comb begin
        state_d        = state_q;
        rows_d         = rows_q;
        cols_d         = cols_q;
        kern_d         = kern_q;
        row_d          = row_q;
        col_d          = col_q;
        depth_d        = depth_q;
        out_data_d     = out_data_q;
        out_row_d      = out_row_q;
        out_col_d      = out_col_q;
        out_depth_d    = out_depth_q;
        out_last_d     = out_last_q;
        job_complete_d = job_complete_q;
        sel_data       = '0;
        can_load       = !out_valid_q || out_ready;
        // channel index is the low bits of depth since C_NUM_CH is a power of two
        sel            = depth_q & C_DEPTH_WIDTH'(C_NUM_CH - 1);
        for (int i = 0; i < C_NUM_CH; i++) begin
            result_accept[i] = (state_q == RUN) && can_load && (sel == C_DEPTH_WIDTH'(i));
            if (result_accept[i]) sel_data = result_data[i*C_DATA_WIDTH +: C_DATA_WIDTH];
        end
        xfer        = |(result_valid & result_accept);
        depth_wrap  = depth_q == kern_q - C_DEPTH_WIDTH'(1);
        col_wrap    = col_q == cols_q - C_COL_WIDTH'(1);
        last_hit    = depth_wrap && col_wrap && (row_q == rows_q - C_ROW_WIDTH'(1));
        out_valid_d = xfer || (out_valid_q && !out_ready);
        if (xfer) begin
            out_data_d  = sel_data;
            out_row_d   = row_q;
            out_col_d   = col_q;
            out_depth_d = depth_q;
            out_last_d  = last_hit;
            depth_d     = depth_wrap ? '0 : depth_q + C_DEPTH_WIDTH'(1);
            col_d       = depth_wrap ? (col_wrap ? '0 : col_q + C_COL_WIDTH'(1)) : col_q;
            row_d       = (depth_wrap && col_wrap) ? row_q + C_ROW_WIDTH'(1) : row_q;
        end else if (out_valid_q && out_ready) begin
            out_last_d = 1'b0;
        end
        case (state_q)
            IDLE: if (cfg_valid) begin
                rows_d  = cfg_num_output_rows;
                cols_d  = cfg_num_output_cols;
                kern_d  = cfg_num_kernels;
                row_d   = '0;
                col_d   = '0;
                depth_d = '0;
                state_d = (cfg_num_output_rows == '0 || cfg_num_output_cols == '0 ||
                           cfg_num_kernels == '0) ? DONE : RUN;
            end
            RUN: state_d = (xfer && last_hit) ? DONE : RUN;
            DONE: begin
                // ack only counts once job_complete is already visible
                job_complete_d = job_complete_q ? !job_complete_ack : !out_valid_d;
                state_d        = (job_complete_q && job_complete_ack) ? IDLE : DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_if) begin
        if (rst) begin
            state_q        <= IDLE;
            rows_q         <= '0;
            cols_q         <= '0;
            kern_q         <= '0;
            row_q          <= '0;
            col_q          <= '0;
            depth_q        <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_row_q      <= '0;
            out_col_q      <= '0;
            out_depth_q    <= '0;
            out_last_q     <= 1'b0;
            job_complete_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rows_q         <= rows_d;
            cols_q         <= cols_d;
            kern_q         <= kern_d;
            row_q          <= row_d;
            col_q          <= col_d;
            depth_q        <= depth_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_row_q      <= out_row_d;
            out_col_q      <= out_col_d;
            out_depth_q    <= out_depth_d;
            out_last_q     <= out_last_d;
            job_complete_q <= job_complete_d;
        end
    end

    assign cfg_ready    = state_q == IDLE;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_row      = out_row_q;
    assign out_col      = out_col_q;
    assign out_depth    = out_depth_q;
    assign out_last     = out_last_q;
    assign job_complete = job_complete_q;
endmodule

// File: tb/tb_cnl_result_collector.sv
// tb_cnl_result_collector: randomized job streams checked against an ordered-output reference model.
module tb_cnl_result_collector;
    logic        clk_if = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [9:0]  cfg_num_output_rows = '0, cfg_num_output_cols = '0, cfg_num_kernels = '0;
    logic [3:0]  result_valid = '0;
    logic [3:0]  result_accept;
    logic [63:0] result_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [9:0]  out_row, out_col, out_depth;
    logic        out_last;
    logic        job_complete;
    logic        job_complete_ack = 1'b0;

    int          checks = 0, errors = 0;
    logic [15:0] gen [4][64];
    int          ptr [4];

    cnl_result_collector dut (
        .clk_if(clk_if), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_num_output_rows(cfg_num_output_rows), .cfg_num_output_cols(cfg_num_output_cols),
        .cfg_num_kernels(cfg_num_kernels), .result_valid(result_valid),
        .result_accept(result_accept), .result_data(result_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_depth(out_depth), .out_last(out_last), .job_complete(job_complete),
        .job_complete_ack(job_complete_ack)
    );

    always #5 clk_if = ~clk_if;

    // rdy_mode: 0 always ready, 1 toggling, 2 random; vld_mode: 0 always valid, 1 random
    task automatic run_job(input int r, input int c, input int k, input int rdy_mode,
                           input int vld_mode, input int hold_ch, input int hold_cyc,
                           input int stop_after, output int last_cyc);
        int total, oi, in_cnt, cyc, exp_ch, cnt [4];
        logic [46:0] exp_q [$];
        logic [46:0] got, prev;
        logic        prev_stall;
        total = r * c * k;
        oi = 0; in_cnt = 0; cyc = 0; prev_stall = 1'b0; prev = '0; last_cyc = -1;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            ptr[i] = 0;
            for (int j = 0; j < 64; j++) gen[i][j] = 16'($urandom);
        end
        // result j of the job sits at depth j%K, column (j/K)%C, row j/(K*C)
        for (int j = 0; j < total; j++) begin
            exp_ch = (j % k) % 4;
            exp_q.push_back({gen[exp_ch][cnt[exp_ch]], 10'(j / (k * c)), 10'((j / k) % c),
                             10'(j % k), 1'(j == total - 1)});
            cnt[exp_ch]++;
        end
        @(negedge clk_if);
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ready_idle: got %b want 1", cfg_ready);
        end
        cfg_num_output_rows = 10'(r);
        cfg_num_output_cols = 10'(c);
        cfg_num_kernels     = 10'(k);
        cfg_valid = 1'b1;
        @(negedge clk_if);
        cfg_valid = 1'b0;
        while (oi < total) begin
            got = {out_data, out_row, out_col, out_depth, out_last};
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || got !== prev) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%b %h want v=1 %h", out_valid, got, prev);
                end
            end
            out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'(cyc % 2 == 0) : 1'($urandom % 2);
            for (int i = 0; i < 4; i++) begin
                result_valid[i] = vld_mode == 0 ? 1'b1 : 1'($urandom % 4 != 0);
                if (i == hold_ch && cyc < hold_cyc) result_valid[i] = 1'b0;
                result_data[i*16 +: 16] = gen[i][ptr[i] & 63];
            end
            #1;
            exp_ch = (in_cnt % k) % 4;
            checks++;
            if (in_cnt < total ? (result_accept !== 4'b0 && result_accept !== 4'(1 << exp_ch))
                               : (result_accept !== 4'b0)) begin
                errors++;
                $display("FAIL accept_channel: got %b want 0 or channel %0d", result_accept, exp_ch);
            end
            if (hold_ch >= 0 && cyc >= 5 && cyc < hold_cyc) begin
                checks++;
                if (result_accept !== 4'(1 << hold_ch)) begin
                    errors++;
                    $display("FAIL withhold_accept: got %b want %b", result_accept, 4'(1 << hold_ch));
                end
            end
            checks++;
            if (job_complete !== 1'b0) begin
                errors++;
                $display("FAIL job_complete_early: got %b want 0", job_complete);
            end
            for (int i = 0; i < 4; i++) if (result_valid[i] && result_accept[i]) begin
                ptr[i]++;
                in_cnt++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (got !== exp_q[oi]) begin
                    errors++;
                    $display("FAIL output_%0d: got {data,row,col,depth,last}=%h want %h", oi, got, exp_q[oi]);
                end
                oi++;
                last_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev = got;
            if (stop_after > 0 && oi == stop_after) return;
            cyc++;
            if (cyc > 3000) begin
                errors++;
                $display("FAIL job_timeout: got %0d outputs want %0d", oi, total);
                break;
            end
            @(negedge clk_if);
        end
        result_valid = '0;
        @(negedge clk_if);
        checks++;
        if (job_complete !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL job_complete_rise: got jc=%b v=%b want jc=1 v=0", job_complete, out_valid);
        end
        job_complete_ack = 1'b1;
        @(negedge clk_if);
        job_complete_ack = 1'b0;
        checks++;
        if (cfg_ready !== 1'b1 || job_complete !== 1'b0) begin
            errors++;
            $display("FAIL ack_to_idle: got ready=%b jc=%b want ready=1 jc=0", cfg_ready, job_complete);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk_if);
        checks++;
        if ({cfg_ready, result_accept, out_valid, out_data, out_row, out_col, out_depth, out_last,
             job_complete} !== {1'b1, 4'b0, 1'b0, 16'b0, 30'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got ready=%b acc=%b v=%b data=%h last=%b jc=%b want ready=1 rest 0",
                     cfg_ready, result_accept, out_valid, out_data, out_last, job_complete);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        int lc;
        run_job(2, 2, 4, 0, 0, -1, 0, 0, lc);
        checks++;
        if (lc !== 16) begin
            errors++;
            $display("FAIL stream_throughput: got last pop at cycle %0d want 16", lc);
        end
    endtask

    task automatic test_backpressure();
        int lc;
        run_job(2, 2, 4, 1, 0, -1, 0, 0, lc);
    endtask

    task automatic test_k6();
        int lc;
        run_job(2, 2, 6, 0, 0, -1, 0, 0, lc);
        run_job(2, 2, 6, 2, 1, -1, 0, 0, lc);
    endtask

    task automatic test_withhold();
        int lc;
        run_job(2, 2, 4, 0, 0, 2, 22, 0, lc);
    endtask

    task automatic test_random_cfg();
        int lc;
        for (int n = 0; n < 4; n++)
            run_job(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), int'($urandom_range(1, 7)),
                    2, 1, -1, 0, 0, lc);
    endtask

    task automatic test_zero_cfg();
        @(negedge clk_if);
        cfg_num_output_rows = 10'd0;
        cfg_num_output_cols = 10'd2;
        cfg_num_kernels     = 10'd4;
        result_valid = 4'hf;
        cfg_valid = 1'b1;
        @(negedge clk_if);
        cfg_valid = 1'b0;
        checks++;
        if ({cfg_ready, out_valid, job_complete, result_accept} !== 7'b0) begin
            errors++;
            $display("FAIL zero_cfg_enter: got ready=%b v=%b jc=%b acc=%b want all 0",
                     cfg_ready, out_valid, job_complete, result_accept);
        end
        repeat (3) begin
            @(negedge clk_if);
            checks++;
            if (job_complete !== 1'b1 || cfg_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL zero_cfg_hold: got jc=%b ready=%b v=%b want 1 0 0", job_complete, cfg_ready, out_valid);
            end
        end
        job_complete_ack = 1'b1;
        @(negedge clk_if);
        job_complete_ack = 1'b0;
        result_valid = '0;
        checks++;
        if (cfg_ready !== 1'b1 || job_complete !== 1'b0) begin
            errors++;
            $display("FAIL zero_cfg_ack: got ready=%b jc=%b want 1 0", cfg_ready, job_complete);
        end
    endtask

    task automatic test_mid_reset();
        int lc;
        run_job(2, 2, 4, 0, 0, -1, 0, 5, lc);
        @(negedge clk_if);
        rst = 1'b1;
        @(negedge clk_if);
        rst = 1'b0;
        result_valid = '0;
        checks++;
        if (out_valid !== 1'b0 || cfg_ready !== 1'b1 || result_accept !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b ready=%b acc=%b want 0 1 0", out_valid, cfg_ready, result_accept);
        end
        run_job(2, 2, 4, 0, 0, -1, 0, 0, lc);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_k6();
        test_withhold();
        test_zero_cfg();
        test_random_cfg();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
